counter: RTL and testbench

Free-running up-counter with selectable saturation, used as a generic cycle/event tally in datapath and control blocks. Counts by one every clock; at the maximum value it either wraps to zero or holds, depending on the `satEn` control input. Purely synchronous apart from the asynchronous reset, with no handshake.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/counter_next.sv | 37 +++
 rtl/counter.sv | 64 ++++++
 tb/tb_counter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Brief  : Shared width default, maximum-value helper and count type for the
//          saturating/wrapping up-counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam int unsigned COUNTER_DEFAULT_WIDTH = 4;

    // All-ones value of a counter of the given width (2..32).
    function automatic logic [31:0] counter_max(input int unsigned width);
        return 32'hFFFF_FFFF >> (32 - width);
    endfunction

    typedef logic [COUNTER_DEFAULT_WIDTH-1:0] count_t;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_next.sv
// ============================================================================
// Module : counter_next
// Brief  : Combinational next-count logic: increment below MAX, then hold or
//          wrap at MAX depending on the saturation enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_sat_en,
    output logic [WIDTH-1:0] o_next_count
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(counter_max(WIDTH));
    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             w_at_max;
    logic [WIDTH-1:0] w_incremented;

    always_comb begin
        w_at_max      = (i_count == C_MAX);
        // No carry-out: MAX + 1 overflows naturally to zero.
        w_incremented = i_count + C_ONE;
        o_next_count  = w_incremented;
        if (w_at_max && i_sat_en) begin
            o_next_count = i_count;
        end
    end

endmodule : counter_next

`default_nettype wire

// File: rtl/counter.sv
// ============================================================================
// Module : counter
// Brief  : Free-running up-counter with selectable saturation at MAX and an
//          asynchronous active-low reset. Optional checks: COUNTER_ASSERTIONS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             satEn,
    output logic [WIDTH-1:0] output_data
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    counter_next #(
        .WIDTH (WIDTH)
    ) u_counter_next (
        .i_count      (count_q),
        .i_sat_en     (satEn),
        .o_next_count (count_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign output_data = count_q;

`ifdef COUNTER_ASSERTIONS_EN
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(counter_max(WIDTH));
    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_width_check
        $error("counter: WIDTH must be in 2..32");
    end

    a_increment: assert property (@(posedge clk) disable iff (!reset)
        (count_q != C_MAX) |=> (count_q == $past(count_q) + C_ONE));

    a_hold_at_max: assert property (@(posedge clk) disable iff (!reset)
        ((count_q == C_MAX) && satEn) |=> (count_q == C_MAX));

    a_wrap_at_max: assert property (@(posedge clk) disable iff (!reset)
        ((count_q == C_MAX) && !satEn) |=> (count_q == '0));

    a_zero_in_reset: assert property (@(posedge clk)
        !reset |-> (output_data == '0));
`endif

endmodule : counter

`default_nettype wire

// File: tb/tb_counter.sv
// ============================================================================
// Module : tb_counter
// Brief  : Directed self-checking bench for the default-width (4-bit) counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter;

    localparam int unsigned C_WIDTH = 4;

    logic               clk;
    logic               reset;
    logic               satEn;
    logic [C_WIDTH-1:0] output_data;

    int checks;
    int errors;

    counter #(
        .WIDTH (C_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .satEn       (satEn),
        .output_data (output_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Reset held for one cycle, then 1..15 and wrap to 0 on the 16th edge.
    task automatic test_reset_and_wrap();
        reset = 1'b0;
        satEn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (output_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_value: got %0d expected 0", output_data);
        end
        reset = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'(i)) begin
                errors++;
                $display("FAIL count_up: got %0d expected %0d", output_data, i);
            end
        end
        @(negedge clk);
        checks++;
        if (output_data !== 4'd0) begin
            errors++;
            $display("FAIL wrap: got %0d expected 0", output_data);
        end
    endtask

    // 17th edge gives 1, then satEn=1: climb to 15 and hold for 12 more edges.
    task automatic test_saturate();
        @(negedge clk);
        checks++;
        if (output_data !== 4'd1) begin
            errors++;
            $display("FAIL edge17: got %0d expected 1", output_data);
        end
        satEn = 1'b1;
        for (int i = 2; i <= 15; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'(i)) begin
                errors++;
                $display("FAIL sat_climb: got %0d expected %0d", output_data, i);
            end
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'd15) begin
                errors++;
                $display("FAIL sat_hold: got %0d expected 15", output_data);
            end
        end
    endtask

    // Held at 15, drop satEn: 0 then 1, 2, 3.
    task automatic test_desaturate();
        satEn = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'(i)) begin
                errors++;
                $display("FAIL desat: got %0d expected %0d", output_data, i);
            end
        end
    endtask

    // From 3, step to 5, assert satEn: 6..15 without stalling, then hold.
    task automatic test_sat_midcount();
        for (int i = 4; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'(i)) begin
                errors++;
                $display("FAIL pre_sat: got %0d expected %0d", output_data, i);
            end
        end
        satEn = 1'b1;
        for (int i = 6; i <= 15; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'(i)) begin
                errors++;
                $display("FAIL mid_sat_climb: got %0d expected %0d", output_data, i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'd15) begin
                errors++;
                $display("FAIL mid_sat_hold: got %0d expected 15", output_data);
            end
        end
    endtask

    // Wrap from 15 to reach 9, then assert reset mid-cycle.
    task automatic test_async_reset_midcount();
        satEn = 1'b0;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'(i)) begin
                errors++;
                $display("FAIL to_nine: got %0d expected %0d", output_data, i);
            end
        end
        @(posedge clk);
        #2;
        checks++;
        if (output_data !== 4'd10) begin
            errors++;
            $display("FAIL before_reset: got %0d expected 10", output_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (output_data !== 4'd0) begin
            errors++;
            $display("FAIL async_clear: got %0d expected 0", output_data);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold: got %0d expected 0", output_data);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (output_data !== 4'(i)) begin
                errors++;
                $display("FAIL post_reset: got %0d expected %0d", output_data, i);
            end
        end
    endtask

    // Saturate at 15, pulse reset between edges: 0 at once, 1 after release.
    task automatic test_reset_from_sat();
        satEn = 1'b1;
        for (int i = 4; i <= 15; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (output_data !== 4'd15) begin
            errors++;
            $display("FAIL sat_before_pulse: got %0d expected 15", output_data);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (output_data !== 4'd0) begin
            errors++;
            $display("FAIL sat_pulse_clear: got %0d expected 0", output_data);
        end
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (output_data !== 4'd0) begin
            errors++;
            $display("FAIL sat_pulse_release: got %0d expected 0", output_data);
        end
        @(negedge clk);
        checks++;
        if (output_data !== 4'd1) begin
            errors++;
            $display("FAIL sat_pulse_restart: got %0d expected 1", output_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        satEn  = 1'b0;
        test_reset_and_wrap();
        test_saturate();
        test_desaturate();
        test_sat_midcount();
        test_async_reset_midcount();
        test_reset_from_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter

`default_nettype wire
